// File: rtl/gol_input_conditioner.sv
// Synchronises, debounces and edge-detects five push buttons into game-of-life control pulses.
// Press-to-pulse latency is DEBOUNCE_CYCLES+3 edges; move buttons auto-repeat while held. There is no backpressure.
module gol_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int REPEAT_DELAY    = 32,
    parameter int REPEAT_PERIOD   = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_pause,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic       pause,
    output logic       moveleft,
    output logic       moveright,
    output logic       moveup,
    output logic       movedown,
    output logic [4:0] held
);

    localparam logic [15:0] DB_LAST     = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] DELAY_LOAD  = 16'(REPEAT_DELAY - 1);
    localparam logic [15:0] PERIOD_LOAD = 16'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {RELEASED, DELAY, REPEAT} move_state_t;

    logic [4:0] raw;
    logic [4:0] stable;
    logic [3:0] eff;
    logic [3:0] mv;
    logic       pause_d;

    assign raw  = {btn_down, btn_up, btn_right, btn_left, btn_pause};
    assign held = stable;

    for (genvar b = 0; b < 5; b++) begin : g_btn
        logic        s1;
        logic        s2;
        logic        stb;
        logic [15:0] cnt;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                s1  <= 1'b0;
                s2  <= 1'b0;
                stb <= 1'b0;
                cnt <= '0;
            end else begin
                s1 <= raw[b];
                s2 <= s1;
                if (s2 != stb) begin
                    if (cnt == DB_LAST) begin
                        stb <= ~stb;
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end else begin
                    cnt <= '0;
                end
            end
        end

        assign stable[b] = stb;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pause_d <= 1'b0;
            pause   <= 1'b0;
        end else begin
            pause_d <= stable[0];
            pause   <= stable[0] & ~pause_d;
        end
    end

    // Opposite directions cancel each other: a direction is only live while its partner is released.
    assign eff = {stable[4] & ~stable[3], stable[3] & ~stable[4],
                  stable[2] & ~stable[1], stable[1] & ~stable[2]};

    for (genvar m = 0; m < 4; m++) begin : g_move
        move_state_t state;
        logic [15:0] timer;
        logic        pulse;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state <= RELEASED;
                timer <= '0;
                pulse <= 1'b0;
            end else begin
                pulse <= 1'b0;
                case (state)
                    RELEASED: begin
                        if (eff[m]) begin
                            pulse <= 1'b1;
                            timer <= DELAY_LOAD;
                            state <= DELAY;
                        end
                    end
                    DELAY, REPEAT: begin
                        if (!eff[m]) begin
                            state <= RELEASED;
                            timer <= '0;
                        end else if (timer == '0) begin
                            pulse <= 1'b1;
                            timer <= PERIOD_LOAD;
                            state <= REPEAT;
                        end else begin
                            timer <= timer - 16'd1;
                        end
                    end
                    default: state <= RELEASED;
                endcase
            end
        end

        assign mv[m] = pulse;
    end

    assign moveleft  = mv[0];
    assign moveright = mv[1];
    assign moveup    = mv[2];
    assign movedown  = mv[3];

endmodule

// File: tb/tb_gol_input_conditioner.sv
// Randomised and directed bench: a scoreboard queue fed by a timing model derived from the press/repeat rules.
module tb_gol_input_conditioner;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [4:0] btn = 5'b0;
    logic       pause, moveleft, moveright, moveup, movedown;
    logic [4:0] held;

    int checks = 0;
    int errors = 0;

    gol_input_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .btn_pause(btn[0]),
        .btn_left (btn[1]),
        .btn_right(btn[2]),
        .btn_up   (btn[3]),
        .btn_down (btn[4]),
        .pause    (pause),
        .moveleft (moveleft),
        .moveright(moveright),
        .moveup   (moveup),
        .movedown (movedown),
        .held     (held)
    );

    always #5 clk = ~clk;

    // Reference model: a button's level flips once the last D synchronised samples
    // (raw delayed two edges) all disagree with it; moves pulse at run ages 0, RD, RD+k*RP.
    logic [63:0] hist [5];
    logic [4:0]  hm;
    logic        pprev;
    int          age [4];
    logic [3:0]  effm;
    logic [3:0]  mp;
    logic        ep;
    logic        all_diff;
    logic [9:0]  exp_q [$];

    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 5; i++) hist[i] = '0;
            hm    = '0;
            pprev = 1'b0;
            for (int i = 0; i < 4; i++) age[i] = -1;
            exp_q.push_back(10'b0);
        end else begin
            ep      = hm[0] & ~pprev;
            pprev   = hm[0];
            effm[0] = hm[1] & ~hm[2];
            effm[1] = hm[2] & ~hm[1];
            effm[2] = hm[3] & ~hm[4];
            effm[3] = hm[4] & ~hm[3];
            for (int d = 0; d < 4; d++) begin
                if (effm[d]) begin
                    age[d] = age[d] + 1;
                    mp[d]  = (age[d] == 0) || (age[d] == RD) ||
                             (age[d] > RD && ((age[d] - RD) % RP) == 0);
                end else begin
                    age[d] = -1;
                    mp[d]  = 1'b0;
                end
            end
            for (int b = 0; b < 5; b++) begin
                all_diff = 1'b1;
                for (int j = 1; j <= D; j++)
                    if (hist[b][j] == hm[b]) all_diff = 1'b0;
                if (all_diff) hm[b] = ~hm[b];
                hist[b] = {hist[b][62:0], btn[b]};
            end
            exp_q.push_back({hm, ep, mp[0], mp[1], mp[2], mp[3]});
        end
    end

    function automatic logic [9:0] outs();
        return {held, pause, moveleft, moveright, moveup, movedown};
    endfunction

    always @(negedge clk) begin
        logic [9:0] e;
        logic [9:0] a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = outs();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL scoreboard t=%0t actual=%b required=%b", $time, a, e);
            end
        end
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic logic out_bit(input int id);
        case (id)
            0:       return pause;
            1:       return moveleft;
            2:       return moveright;
            3:       return moveup;
            4:       return movedown;
            default: return 1'b0;
        endcase
    endfunction

    int cnt;
    int offs [8];

    // k = 0 is the negedge right after the first edge that samples the new input state.
    task automatic run_watch(input int id, input int n, input int rel_k, input int rel_b);
        cnt = 0;
        for (int i = 0; i < 8; i++) offs[i] = -1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (out_bit(id)) begin
                if (cnt < 8) offs[cnt] = k;
                cnt++;
            end
            if (k == rel_k) btn[rel_b] = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    int dur [5];
    int up_exp [7] = '{6, 16, 19, 22, 25, 28, 31};

    initial begin
        idle(2);
        check("reset_state", int'(outs()), 0);
        #2 reset_n = 1'b1;
        idle(3);

        // Clean pause press held 40 cycles
        btn[0] = 1'b1;
        run_watch(0, 40, 39, 0);
        check("pause_count", cnt, 1);
        check("pause_offset", offs[0], D + 2);
        idle(15);

        // Bounce on left, then steady
        for (int i = 0; i < 4; i++) begin
            btn[1] = (i % 2 == 0);
            idle(2);
        end
        btn[1] = 1'b1;
        run_watch(1, 16, -1, 0);
        check("bounce_count", cnt, 1);
        check("bounce_offset", offs[0], D + 2);
        btn[1] = 1'b0;
        idle(15);

        // Auto-repeat on up, raw released after 28 sampled edges
        btn[3] = 1'b1;
        run_watch(3, 45, 27, 3);
        check("repeat_count", cnt, 7);
        for (int i = 0; i < 7; i++) check("repeat_offset", offs[i], up_exp[i]);
        idle(10);

        // Opposite conflict: left held, then right
        btn[1] = 1'b1;
        idle(20);
        btn[2] = 1'b1;
        idle(8);
        run_watch(1, 12, -1, 0);
        check("conflict_quiet", cnt, 0);
        btn[2] = 1'b0;
        run_watch(1, 19, -1, 0);
        check("conflict_count", cnt, 2);
        check("conflict_first", offs[0], D + 2);
        check("conflict_repeat", offs[1], D + 2 + RD);
        btn[1] = 1'b0;
        idle(15);

        // Reset while down is held
        btn[4] = 1'b1;
        idle(20);
        #2 reset_n = 1'b0;
        idle(3);
        #2 reset_n = 1'b1;
        run_watch(4, 22, -1, 0);
        check("rst_hold_count", cnt, 3);
        check("rst_hold_first", offs[0], D + 2);
        check("rst_hold_rep1", offs[1], D + 2 + RD);
        check("rst_hold_rep2", offs[2], D + 2 + RD + RP);
        btn[4] = 1'b0;
        idle(15);

        // Random levels with mixed short bounces and long holds, with an async reset mid-run
        for (int b = 0; b < 5; b++) dur[b] = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            for (int b = 0; b < 5; b++) begin
                if (dur[b] == 0) begin
                    btn[b] = 1'($urandom_range(0, 1));
                    dur[b] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                          : int'($urandom_range(5, 50));
                end else begin
                    dur[b]--;
                end
            end
            if (cyc == 700) begin
                #2 reset_n = 1'b0;
                #1 check("reset_async", int'(outs()), 0);
                repeat (2) begin
                    @(negedge clk);
                    btn = 5'($urandom);
                end
                @(negedge clk);
                #2 reset_n = 1'b1;
            end
        end
        btn = 5'b0;
        idle(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
